// File: rtl/enemy_pool.sv
// -----------------------------------------------------------------------------
// enemy_pool
//   Pool of N_ENEMY walking (goomba-class) enemies. Each slot owns its world
//   position, walking direction and a small IDLE/WALK/SQUISH state machine.
//   New enemies arrive through a valid/ready spawn handshake. Motion and
//   collision against mario are evaluated on every frame tick (rising edge of
//   the VGA vertical sync). A registered pixel path tells the color mapper
//   which slot, if any, covers the current pixel and which sprite texel to use.
//
//   Optional build macro: ENEMY_POOL_MUTUAL_BOUNCE_EN
//     When defined, two walking enemies whose post-move boxes overlap both
//     reverse direction on that tick. When undefined, enemies pass through
//     each other and no pairwise compare logic exists.
//
// Ports
//   Clk, Reset          system clock, synchronous active-high reset
//   frame_clk           VGA_VS; synchronised here, rising edge = frame tick
//   spawn_valid/_x/_dir spawn request (dir 1 = right, 0 = left)
//   spawn_ready         at least one slot is IDLE
//   mario_x, mario_y    mario top-left (world x, screen y)
//   mario_y_motion      signed vertical speed, > 0 means falling
//   mario_alive         0 freezes all motion, squish timers and collision
//   process             scroll offset, screen_x = world_x - process
//   DrawX, DrawY        current VGA pixel
//   enemy_px            pixel is covered by an enemy (registered)
//   enemy_idx           slot owning that pixel, lowest index wins (registered)
//   enemy_squished      owning slot is squished (registered)
//   rom_addr            sprite ROM texel address (registered)
//   alive_mask          bit i set while slot i is walking
//   stomp_pulse         one-cycle pulse after a tick with at least one stomp
//   mario_hit           sticky side/below contact flag, cleared by Reset only
//   stomp_count         saturating total of stomped enemies
// -----------------------------------------------------------------------------
module enemy_pool #(
    parameter int N_ENEMY       = 4,
    parameter int X_MIN         = 0,
    parameter int X_MAX         = 639,
    parameter int GROUND_Y      = 400,
    parameter int SPR_W         = 32,
    parameter int SPR_H         = 32,
    parameter int SPEED         = 1,
    parameter int SQUISH_FRAMES = 30,
    parameter int STOMP_TOL     = 8,
    localparam int IDX_W  = (N_ENEMY > 1) ? $clog2(N_ENEMY) : 1,
    localparam int ADDR_W = (SPR_W * SPR_H > 1) ? $clog2(SPR_W * SPR_H) : 1
) (
    input  logic                Clk,
    input  logic                Reset,
    input  logic                frame_clk,
    input  logic                spawn_valid,
    input  logic [9:0]          spawn_x,
    input  logic                spawn_dir,
    output logic                spawn_ready,
    input  logic [9:0]          mario_x,
    input  logic [9:0]          mario_y,
    input  logic [9:0]          mario_y_motion,
    input  logic                mario_alive,
    input  logic [9:0]          process,
    input  logic [9:0]          DrawX,
    input  logic [9:0]          DrawY,
    output logic                enemy_px,
    output logic [IDX_W-1:0]    enemy_idx,
    output logic                enemy_squished,
    output logic [ADDR_W-1:0]   rom_addr,
    output logic [N_ENEMY-1:0]  alive_mask,
    output logic                stomp_pulse,
    output logic                mario_hit,
    output logic [15:0]         stomp_count
);

    localparam int CNT_W = (SQUISH_FRAMES > 1) ? $clog2(SQUISH_FRAMES) : 1;

    // 12-bit signed views so that x +/- SPEED can never wrap silently
    localparam logic signed [11:0] C_SPEED  = 12'(SPEED);
    localparam logic signed [11:0] C_XMIN   = 12'(X_MIN);
    localparam logic signed [11:0] C_XMAX   = 12'(X_MAX);
    localparam logic signed [11:0] C_SPRW_S = 12'(SPR_W);
    localparam logic signed [11:0] C_SPRH_S = 12'(SPR_H);
    localparam logic [11:0]        C_SPRH_U = 12'(SPR_H);
    localparam logic [11:0]        C_TOL_U  = 12'(STOMP_TOL);
    localparam logic [9:0]         C_XMIN10 = 10'(X_MIN);
    localparam logic [9:0]         C_XMAX10 = 10'(X_MAX);
    localparam logic [9:0]         C_SPRW10 = 10'(SPR_W);
    localparam logic [9:0]         C_SPRH10 = 10'(SPR_H);
    localparam logic [9:0]         C_GROUND = 10'(GROUND_Y);
    localparam logic [CNT_W-1:0]   C_SQ_INIT = CNT_W'(SQUISH_FRAMES - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_WALK   = 2'd1,
        S_SQUISH = 2'd2
    } slot_state_t;

    // Per-slot state
    slot_state_t        r_state [N_ENEMY];
    logic [9:0]         r_x     [N_ENEMY];
    logic [9:0]         r_y     [N_ENEMY];
    logic               r_dir   [N_ENEMY];
    logic [CNT_W-1:0]   r_cnt   [N_ENEMY];

    // frame_clk synchroniser and edge detector
    logic r_fc_s1, r_fc_s2, r_fc_s3;
    logic w_tick, w_tick_live;

    // Spawn selection
    logic [N_ENEMY-1:0] w_spawn_sel;
    logic               w_any_idle;
    logic               w_spawn_go;

    // Tick evaluation
    logic [9:0]         w_nx    [N_ENEMY];
    logic               w_ndir  [N_ENEMY];
    logic [N_ENEMY-1:0] w_stomp;
    logic [N_ENEMY-1:0] w_hit;
    logic [N_ENEMY-1:0] w_flip;
    logic [4:0]         w_pop;
    logic [16:0]        w_cnt_sum;

    // Pixel path (combinational stage feeding the output registers)
    logic               w_pix_hit;
    logic [IDX_W-1:0]   w_pix_idx;
    logic               w_pix_sq;
    logic [ADDR_W-1:0]  w_pix_addr;

    assign w_tick      = r_fc_s2 & ~r_fc_s3;
    assign w_tick_live = w_tick & mario_alive;

    // Lowest-index IDLE slot, judged on the state at the start of the cycle
    always_comb begin
        w_spawn_sel = '0;
        w_any_idle  = 1'b0;
        for (int i = 0; i < N_ENEMY; i++) begin
            if (r_state[i] == S_IDLE && !w_any_idle) begin
                w_spawn_sel[i] = 1'b1;
                w_any_idle     = 1'b1;
            end
        end
    end

    assign spawn_ready = w_any_idle;
    assign w_spawn_go  = spawn_valid & w_any_idle;

    always_comb begin
        alive_mask = '0;
        for (int i = 0; i < N_ENEMY; i++) begin
            alive_mask[i] = (r_state[i] == S_WALK);
        end
    end

    // Post-move position with wall clamping, then collision against mario
    always_comb begin
        logic signed [11:0] v_step;
        logic signed [11:0] v_dx;
        logic signed [11:0] v_dy;
        logic               v_ovl;
        logic               v_fall;
        logic               v_low;
        v_step = '0;
        v_dx   = '0;
        v_dy   = '0;
        v_ovl  = 1'b0;
        v_low  = 1'b0;
        v_fall = $signed(mario_y_motion) > 10'sd0;
        for (int i = 0; i < N_ENEMY; i++) begin
            if (r_dir[i])
                v_step = $signed({2'b00, r_x[i]}) + C_SPEED;
            else
                v_step = $signed({2'b00, r_x[i]}) - C_SPEED;

            if (v_step > C_XMAX) begin
                w_nx[i]   = C_XMAX10;
                w_ndir[i] = 1'b0;
            end else if (v_step < C_XMIN) begin
                w_nx[i]   = C_XMIN10;
                w_ndir[i] = 1'b1;
            end else begin
                w_nx[i]   = v_step[9:0];
                w_ndir[i] = r_dir[i];
            end

            v_dx = $signed({2'b00, mario_x}) - $signed({2'b00, w_nx[i]});
            if (v_dx[11]) v_dx = -v_dx;
            v_dy = $signed({2'b00, mario_y}) - $signed({2'b00, r_y[i]});
            if (v_dy[11]) v_dy = -v_dy;
            v_ovl = (v_dx < C_SPRW_S) && (v_dy < C_SPRH_S);
            // mario's feet no deeper than STOMP_TOL below the enemy's top
            v_low = ({2'b00, mario_y} + C_SPRH_U) <= ({2'b00, r_y[i]} + C_TOL_U);

            w_stomp[i] = (r_state[i] == S_WALK) && v_ovl && v_fall && v_low;
            w_hit[i]   = (r_state[i] == S_WALK) && v_ovl && !(v_fall && v_low);
        end
    end

    // Enemy-vs-enemy bounce on post-wall positions
    always_comb begin
`ifdef ENEMY_POOL_MUTUAL_BOUNCE_EN
        logic signed [11:0] v_d;
        v_d = '0;
`endif
        w_flip = '0;
`ifdef ENEMY_POOL_MUTUAL_BOUNCE_EN
        for (int i = 0; i < N_ENEMY; i++) begin
            for (int j = 0; j < N_ENEMY; j++) begin
                if (i != j && r_state[i] == S_WALK && r_state[j] == S_WALK) begin
                    v_d = $signed({2'b00, w_nx[i]}) - $signed({2'b00, w_nx[j]});
                    if (v_d[11]) v_d = -v_d;
                    if (v_d < C_SPRW_S) w_flip[i] = 1'b1;
                end
            end
        end
`endif
    end

    always_comb begin
        w_pop = '0;
        for (int i = 0; i < N_ENEMY; i++) begin
            w_pop = w_pop + {4'b0000, w_stomp[i]};
        end
    end

    assign w_cnt_sum = {1'b0, stomp_count} + {12'd0, w_pop};

    // Pixel cover search; walking downwards lets the lowest index win
    always_comb begin
        logic [9:0] v_sx;
        logic [9:0] v_dxp;
        logic [9:0] v_dyp;
        logic [9:0] v_col;
        v_sx       = '0;
        v_dxp      = '0;
        v_dyp      = '0;
        v_col      = '0;
        w_pix_hit  = 1'b0;
        w_pix_idx  = '0;
        w_pix_sq   = 1'b0;
        w_pix_addr = '0;
        for (int i = N_ENEMY - 1; i >= 0; i--) begin
            v_sx  = r_x[i] - process;
            // unsigned wrap turns pixels left of / above the sprite into huge values
            v_dxp = DrawX - v_sx;
            v_dyp = DrawY - r_y[i];
            v_col = r_dir[i] ? v_dxp : (C_SPRW10 - 10'd1 - v_dxp);
            if (r_state[i] != S_IDLE && v_dxp < C_SPRW10 && v_dyp < C_SPRH10) begin
                w_pix_hit  = 1'b1;
                w_pix_idx  = IDX_W'(i);
                w_pix_sq   = (r_state[i] == S_SQUISH);
                w_pix_addr = ADDR_W'(({10'd0, v_dyp} * 20'(SPR_W)) + {10'd0, v_col});
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_fc_s1        <= 1'b0;
            r_fc_s2        <= 1'b0;
            r_fc_s3        <= 1'b0;
            for (int i = 0; i < N_ENEMY; i++) begin
                r_state[i] <= S_IDLE;
                r_x[i]     <= '0;
                r_y[i]     <= C_GROUND;
                r_dir[i]   <= 1'b0;
                r_cnt[i]   <= '0;
            end
            stomp_pulse    <= 1'b0;
            mario_hit      <= 1'b0;
            stomp_count    <= '0;
            enemy_px       <= 1'b0;
            enemy_idx      <= '0;
            enemy_squished <= 1'b0;
            rom_addr       <= '0;
        end else begin
            r_fc_s1 <= frame_clk;
            r_fc_s2 <= r_fc_s1;
            r_fc_s3 <= r_fc_s2;

            for (int i = 0; i < N_ENEMY; i++) begin
                if (w_spawn_go && w_spawn_sel[i]) begin
                    r_state[i] <= S_WALK;
                    r_x[i]     <= spawn_x;
                    r_y[i]     <= C_GROUND;
                    r_dir[i]   <= spawn_dir;
                end else if (w_tick_live) begin
                    case (r_state[i])
                        S_WALK: begin
                            r_x[i]   <= w_nx[i];
                            r_dir[i] <= w_ndir[i] ^ w_flip[i];
                            if (w_stomp[i]) begin
                                r_state[i] <= S_SQUISH;
                                r_cnt[i]   <= C_SQ_INIT;
                            end
                        end
                        S_SQUISH: begin
                            if (r_cnt[i] == '0)
                                r_state[i] <= S_IDLE;
                            else
                                r_cnt[i] <= r_cnt[i] - 1'b1;
                        end
                        default: ;
                    endcase
                end
            end

            stomp_pulse <= w_tick_live & (|w_stomp);
            if (w_tick_live && (|w_hit)) mario_hit <= 1'b1;
            if (w_tick_live) begin
                stomp_count <= w_cnt_sum[16] ? 16'hFFFF : w_cnt_sum[15:0];
            end

            enemy_px       <= w_pix_hit;
            enemy_idx      <= w_pix_idx;
            enemy_squished <= w_pix_sq;
            rom_addr       <= w_pix_addr;
        end
    end

endmodule
